alu_resp: RTL and testbench

ALU_RESP -- requirements
Module: alu_resp

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_resp_fifo.sv | 47 ++++
 rtl/alu_resp.sv | 111 +++++++++++
 tb/tb_alu_resp.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding, widths and result-entry layout for the ALU response pipeline.
package alu_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned RES_W = 7;

  typedef enum logic [OP_W-1:0] {
    OpAdd  = 4'd0,
    OpSub  = 4'd1,
    OpMul  = 4'd2,
    OpAnd  = 4'd3,
    OpOr   = 4'd4,
    OpXor  = 4'd5,
    OpNand = 4'd6,
    OpNor  = 4'd7,
    OpXnor = 4'd8,
    OpShl  = 4'd9,
    OpShr  = 4'd10,
    OpCmp  = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic [RES_W-1:0] result;
    logic [OP_W-1:0]  op;
    logic             err;
    logic             ovf;
  } alu_entry_t;

endpackage

// File: rtl/alu_resp_fifo.sv
// Result FIFO; pointers wrap naturally because DEPTH is a power of two.
module alu_resp_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  alu_entry_t             wdata,
  input  logic                   pop,
  output alu_entry_t             rdata,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q;
  alu_entry_t    mem [DEPTH];
  logic          do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  // A pop on the same edge frees the slot, so a full FIFO can still take a push.
  assign do_push = push && ((count_q < (AW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      count_q <= count_q + (AW+1)'(1);
      else if (do_pop && !do_push) count_q <= count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/alu_resp.sv
// Two-stage ALU: capture request, compute on the next edge into a result FIFO.
module alu_resp
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_a,
  input  logic [3:0]       req_b,
  input  logic [OP_W-1:0]  req_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [RES_W-1:0] rsp_result,
  output logic [OP_W-1:0]  rsp_op,
  output logic             rsp_err,
  output logic             rsp_ovf,
  output logic [7:0]       err_count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  function automatic alu_entry_t alu_compute(logic [3:0] a, logic [3:0] b, logic [OP_W-1:0] op);
    alu_entry_t e;
    logic [7:0] prod;
    logic [6:0] ea, eb;
    ea       = {3'b000, a};
    eb       = {3'b000, b};
    prod     = {4'h0, a} * {4'h0, b};
    e.result = '0;
    e.op     = op;
    e.err    = 1'b0;
    e.ovf    = 1'b0;
    case (op)
      OpAdd:   e.result = ea + eb;
      OpSub:   e.result = ea - eb;
      OpMul:   begin
        e.result = prod[6:0];
        e.ovf    = prod[7];
      end
      OpAnd:   e.result = {3'b000, a & b};
      OpOr:    e.result = {3'b000, a | b};
      OpXor:   e.result = {3'b000, a ^ b};
      OpNand:  e.result = {3'b000, ~(a & b)};
      OpNor:   e.result = {3'b000, ~(a | b)};
      OpXnor:  e.result = {3'b000, ~(a ^ b)};
      OpShl:   e.result = ea << b[1:0];
      OpShr:   e.result = ea >> b[1:0];
      OpCmp:   e.result = {5'b00000, a > b, a == b};
      default: e.err    = 1'b1;
    endcase
    return e;
  endfunction

  logic            s1_valid_q;
  logic [3:0]      s1_a_q, s1_b_q;
  logic [OP_W-1:0] s1_op_q;
  logic [7:0]      err_count_q;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupancy;
  logic            accept;
  alu_entry_t      s1_entry, head;

  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, s1_valid_q};
  assign req_ready = occupancy < (CW+1)'(DEPTH);
  assign accept    = req_valid && req_ready;
  assign s1_entry  = alu_compute(s1_a_q, s1_b_q, s1_op_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_op_q     <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_a_q  <= req_a;
        s1_b_q  <= req_b;
        s1_op_q <= req_op;
      end
      if (s1_valid_q && s1_entry.err && (err_count_q != 8'hFF)) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  alu_resp_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s1_valid_q),
    .wdata (s1_entry),
    .pop   (rsp_ready),
    .rdata (head),
    .count (fifo_count)
  );

  // Gate the head so outputs read zero when empty (including during reset).
  assign rsp_valid  = fifo_count != '0;
  assign rsp_result = rsp_valid ? head.result : '0;
  assign rsp_op     = rsp_valid ? head.op : '0;
  assign rsp_err    = rsp_valid && head.err;
  assign rsp_ovf    = rsp_valid && head.ovf;
  assign err_count  = err_count_q;

endmodule

// File: tb/tb_alu_resp.sv
// Randomized and directed checks of alu_resp against a queue-based reference model.
module tb_alu_resp;

  localparam int unsigned DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_ready;
  logic [3:0] req_a, req_b, req_op;
  logic       rsp_valid, rsp_ready;
  logic [6:0] rsp_result;
  logic [3:0] rsp_op;
  logic       rsp_err, rsp_ovf;
  logic [7:0] err_count;

  always #5 clk = ~clk;

  alu_resp #(
    .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .rsp_ovf    (rsp_ovf),
    .err_count  (err_count)
  );

  typedef struct {
    int unsigned res;
    int unsigned op;
    bit          err;
    bit          ovf;
  } exp_t;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state
  exp_t        mq[$];
  bit          s1_v;
  int unsigned s1_a, s1_b, s1_op;
  int unsigned m_err;
  int unsigned cyc;

  // Observed pops and accept edges
  int unsigned got_res[$], got_err[$], got_ovf[$], got_cyc[$], acc_cyc[$];
  int unsigned n_acc;

  task automatic check(string tag, int unsigned got, int unsigned exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic exp_t calc(int unsigned a, int unsigned b, int unsigned op);
    exp_t e;
    int unsigned p;
    e.op  = op;
    e.err = 0;
    e.ovf = 0;
    e.res = 0;
    p = a * b;
    case (op)
      0:  e.res = a + b;
      1:  e.res = (a + 128 - b) % 128;
      2:  begin e.res = p % 128; e.ovf = (p > 127); end
      3:  e.res = a & b;
      4:  e.res = a | b;
      5:  e.res = a ^ b;
      6:  e.res = 15 - (a & b);
      7:  e.res = 15 - (a | b);
      8:  e.res = 15 - (a ^ b);
      9:  e.res = a * (2 ** (b % 4));
      10: e.res = a / (2 ** (b % 4));
      11: e.res = 2 * int'(a > b) + int'(a == b);
      default: e.err = 1;
    endcase
    return e;
  endfunction

  function automatic bit model_ready();
    return (mq.size() + int'(s1_v)) < DEPTH;
  endfunction

  // One clock cycle: called at a negedge, returns at the next negedge.
  task automatic step(bit v, int unsigned a, int unsigned b, int unsigned op, bit rr);
    bit acc, popping;
    exp_t e;
    req_valid = v;
    req_a     = a[3:0];
    req_b     = b[3:0];
    req_op    = op[3:0];
    rsp_ready = rr;
    #1;
    check("rsp_valid", rsp_valid, (mq.size() != 0));
    if (mq.size() != 0) begin
      check("rsp_result", rsp_result, mq[0].res);
      check("rsp_op", rsp_op, mq[0].op);
      check("rsp_err", rsp_err, mq[0].err);
      check("rsp_ovf", rsp_ovf, mq[0].ovf);
    end
    check("req_ready", req_ready, model_ready());
    check("err_count", err_count, m_err);
    acc     = v && model_ready();
    popping = (mq.size() != 0) && rr;
    if (v && req_ready) begin
      n_acc++;
      acc_cyc.push_back(cyc + 1);
    end
    if (rsp_valid && rr) begin
      got_res.push_back(rsp_result);
      got_err.push_back(rsp_err);
      got_ovf.push_back(rsp_ovf);
      got_cyc.push_back(cyc + 1);
    end
    @(posedge clk);
    cyc++;
    if (popping) void'(mq.pop_front());
    if (s1_v) begin
      e = calc(s1_a, s1_b, s1_op);
      mq.push_back(e);
      if (e.err && m_err < 255) m_err++;
    end
    s1_v  = acc;
    s1_a  = a;
    s1_b  = b;
    s1_op = op;
    @(negedge clk);
  endtask

  task automatic idle(int n, bit rr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, rr);
  endtask

  task automatic clear_obs();
    got_res.delete();
    got_err.delete();
    got_ovf.delete();
    got_cyc.delete();
    acc_cyc.delete();
    n_acc = 0;
  endtask

  int unsigned pops;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    rsp_ready = 1'b0;
    s1_v      = 0;
    m_err     = 0;
    cyc       = 0;
    n_acc     = 0;
    #3;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_err_count", err_count, 0);
    check("rst_rsp_result", rsp_result, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Back-to-back ADD/SUB/MUL with latency and throughput checks
    clear_obs();
    step(1, 6, 4, 0, 1);
    step(1, 6, 4, 1, 1);
    step(1, 6, 4, 2, 1);
    idle(4, 1);
    check("b2b_count", got_res.size(), 3);
    if (got_res.size() == 3 && acc_cyc.size() == 3) begin
      check("b2b_add", got_res[0], 10);
      check("b2b_sub", got_res[1], 2);
      check("b2b_mul", got_res[2], 24);
      check("b2b_latency", got_cyc[0] - acc_cyc[0], 2);
      check("b2b_consec1", got_cyc[1] - got_cyc[0], 1);
      check("b2b_consec2", got_cyc[2] - got_cyc[1], 1);
    end

    // Arithmetic corner cases
    clear_obs();
    step(1, 4, 6, 1, 1);
    step(1, 15, 15, 2, 1);
    step(1, 8, 5, 2, 1);
    idle(4, 1);
    check("corner_count", got_res.size(), 3);
    if (got_res.size() == 3) begin
      check("sub_wrap", got_res[0], 126);
      check("mul_ovf_res", got_res[1], 97);
      check("mul_ovf_flag", got_ovf[1], 1);
      check("mul_noovf_res", got_res[2], 40);
      check("mul_noovf_flag", got_ovf[2], 0);
    end

    // Stall: exactly DEPTH accepted, then in-order drain
    clear_obs();
    for (int i = 0; i < 8; i++) step(1, i, i + 1, i % 12, 0);
    check("stall_accepts", n_acc, DEPTH);
    check("stall_ready_low", req_ready, 0);
    idle(DEPTH + 2, 1);
    check("stall_drained", got_res.size(), DEPTH);

    // Illegal opcodes and error-count saturation
    clear_obs();
    for (int i = 0; i < 3; i++) step(1, 9, 3, 13, 1);
    idle(3, 1);
    check("err_count3", err_count, 3);
    check("err_pops", got_res.size(), 3);
    for (int i = 0; i < got_res.size(); i++) begin
      check("err_flag", got_err[i], 1);
      check("err_result", got_res[i], 0);
    end
    for (int i = 0; i < 300; i++) step(1, $urandom_range(0, 15), $urandom_range(0, 15), 12 + (i % 4), 1);
    idle(3, 1);
    check("err_sat", err_count, 255);

    // Full FIFO with continuous stream: one result per cycle
    clear_obs();
    for (int i = 0; i < 6; i++) step(1, i, 2, 0, 0);
    pops = 0;
    for (int i = 0; i < 40; i++) begin
      step(1, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 11), 1);
      if (i >= 5) pops = pops + ((got_res.size() == DEPTH ? 0 : 0));
    end
    check("sustain_pops", got_res.size(), 40);
    idle(DEPTH + 2, 1);
    check("sustain_empty", mq.size(), 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 15), ($urandom_range(0, 9) < 6));
    end
    idle(DEPTH + 4, 1);

    // Reset with queued entries
    clear_obs();
    for (int i = 0; i < 3; i++) step(1, 3, 3, 0, 0);
    idle(1, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_req_ready", req_ready, 1);
    check("midrst_err_count", err_count, 0);
    mq.delete();
    s1_v  = 0;
    m_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_obs();
    step(1, 8, 5, 0, 1);
    idle(5, 1);
    check("postrst_count", got_res.size(), 1);
    if (got_res.size() == 1) check("postrst_add", got_res[0], 13);
    check("postrst_latency", (got_cyc.size() == 1 && acc_cyc.size() == 1) ?
          got_cyc[0] - acc_cyc[0] : 0, 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got %0d cycles expected completion", cyc);
    $fatal(1);
  end

endmodule
